punc_datapath: RTL

Datapath for the PUnC LC3 processor: program counter, instruction register, 8x16 register file, ALU, NZP condition codes and the LDI indirection register. It executes the one-cycle control vectors issued by the PUnC control FSM. It returns `ir` and `n`/`z`/`p` to the FSM and drives the external asynchronous-read, synchronous-write 16-bit memory.

---
 rtl/punc_datapath_if.sv | 25 ++
 rtl/punc_datapath.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/punc_datapath_if.sv
// Memory bus between the PUnC datapath and its asynchronous-read,
// synchronous-write 16-bit memory.
interface punc_datapath_if;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic [15:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr;

    modport master (
        output mem_rd_addr,
        output mem_wr_addr,
        output mem_wr_data,
        output mem_wr,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_addr,
        input  mem_wr_addr,
        input  mem_wr_data,
        input  mem_wr,
        output mem_rd_data
    );
endinterface

// File: rtl/punc_datapath.sv
// PUnC LC3 datapath: PC, IR, 8x16 register file, ALU, NZP flags and
// the LDI pointer register, driven by one-cycle control vectors.
module punc_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w_en,
    input  logic [1:0]  mem_w_addr_sel,
    input  logic        mem_w_data_sel,
    input  logic [1:0]  mem_r_addr_sel,
    input  logic        rf_w_en,
    input  logic        rf_w_addr_sel,
    input  logic [1:0]  rf_w_data_sel,
    input  logic        rf_r0_addr_sel,
    input  logic        rf_r1_addr_sel,
    input  logic        ir_ld,
    input  logic        pc_ld,
    input  logic        pc_clr,
    input  logic        pc_inc,
    input  logic [1:0]  pc_ld_data_sel,
    input  logic [2:0]  alu_sel,
    input  logic        cond_ld,
    input  logic        cond_ld_data_sel,
    input  logic        ldi_reg_ld,
    punc_datapath_if.master bus,
    output logic [15:0] ir,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [15:0] pc_dbg
);

    logic [15:0] pc;
    logic [15:0] ldi_reg;
    logic [15:0] rf [8];

    logic [15:0] sext5, sext6, sext9, sext11;
    logic [15:0] pc_off9;
    logic [2:0]  r0_addr, r1_addr, w_addr;
    logic [15:0] r0, r1;
    logic [15:0] alu;
    logic [15:0] wdata;
    logic [15:0] flag_src;
    logic [15:0] pc_next;

    // Both data-select codes pick r0; the input is kept for the FSM's benefit.
    logic unused_w_data_sel;
    assign unused_w_data_sel = mem_w_data_sel;

    assign sext5  = {{11{ir[4]}}, ir[4:0]};
    assign sext6  = {{10{ir[5]}}, ir[5:0]};
    assign sext9  = {{7{ir[8]}}, ir[8:0]};
    assign sext11 = {{5{ir[10]}}, ir[10:0]};
    assign pc_off9 = pc + sext9;

    assign r0_addr = rf_r0_addr_sel ? ir[11:9] : ir[8:6];
    assign r1_addr = rf_r1_addr_sel ? ir[8:6] : ir[2:0];
    assign w_addr  = rf_w_addr_sel ? 3'd7 : ir[11:9];
    assign r0 = rf[r0_addr];
    assign r1 = rf[r1_addr];

    always_comb begin
        case (alu_sel)
            3'd0:    alu = r0 + r1;
            3'd1:    alu = r0 + sext5;
            3'd2:    alu = r0 & r1;
            3'd3:    alu = r0 & sext5;
            3'd4:    alu = ~r0;
            3'd5:    alu = r0;
            default: alu = '0;
        endcase
    end

    always_comb begin
        case (rf_w_data_sel)
            2'd0:    wdata = alu;
            2'd1:    wdata = bus.mem_rd_data;
            2'd2:    wdata = pc;
            default: wdata = pc_off9;
        endcase
    end

    always_comb begin
        case (mem_r_addr_sel)
            2'd0:    bus.mem_rd_addr = pc;
            2'd1:    bus.mem_rd_addr = pc_off9;
            2'd2:    bus.mem_rd_addr = r0 + sext6;
            default: bus.mem_rd_addr = ldi_reg;
        endcase
    end

    // STI takes its target address straight from the word read this cycle.
    always_comb begin
        case (mem_w_addr_sel)
            2'd0:    bus.mem_wr_addr = pc_off9;
            2'd1:    bus.mem_wr_addr = r1 + sext6;
            2'd2:    bus.mem_wr_addr = bus.mem_rd_data;
            default: bus.mem_wr_addr = '0;
        endcase
    end

    assign bus.mem_wr_data = r0;
    assign bus.mem_wr      = mem_w_en;

    always_comb begin
        pc_next = pc;
        if (pc_clr) begin
            pc_next = '0;
        end else if (pc_ld) begin
            case (pc_ld_data_sel)
                2'd0:    pc_next = pc_off9;
                2'd1:    pc_next = r0;
                2'd2:    pc_next = pc + sext11;
                default: pc_next = pc;
            endcase
        end else if (pc_inc) begin
            pc_next = pc + 16'd1;
        end
    end

    assign flag_src = cond_ld_data_sel ? wdata : alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            ldi_reg <= '0;
            n       <= 1'b0;
            z       <= 1'b1;
            p       <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            pc <= pc_next;
            if (ir_ld) ir <= bus.mem_rd_data;
            if (ldi_reg_ld) ldi_reg <= bus.mem_rd_data;
            if (rf_w_en) rf[w_addr] <= wdata;
            if (cond_ld) begin
                n <= flag_src[15];
                z <= (flag_src == 16'd0);
                p <= !flag_src[15] && (flag_src != 16'd0);
            end
        end
    end

    assign pc_dbg = pc;

endmodule
